sync_fifo_ctl: RTL and testbench
================================

// Module: sync_fifo_ctl
// PURPOSE
//  Parametrised synchronous FIFO: next generation of the team's single-clock FIFO.
//  Valid/ready on both sides, with an occupancy count and a peak-occupancy watermark.
//  Adds a synchronous flush and an optional registered output stage for timing closure.
//  Sits between a producer (slave side, _s) and a consumer (master side, _m) in one clock domain.
// PARAMETERS
//  FIFO_DEPTH  16                     capacity in entries; power of 2, >= 4
//  DATA_WIDTH  32                     payload width
//  ADDR_WIDTH  $clog2(FIFO_DEPTH)     pointer width (derived, do not override)
//  OUT_REG     0                      0: o_dataout read combinationally from storage; 1: o_dataout/o_valid_m from flops
// PORTS
//  i_clk              in   1             clock, all state on rising edge
//  i_rst_n            in   1             asynchronous active-low reset
//  i_flush            in   1             synchronous clear of contents, highest priority
//  i_clr_stat         in   1             synchronous clear of o_max_count
//  i_valid_s          in   1             producer has data
//  i_datain           in   DATA_WIDTH    producer data
//  o_ready_s          out  1             FIFO accepts data this cycle
//  o_valid_m          out  1             o_dataout holds the oldest entry
//  o_dataout          out  DATA_WIDTH    oldest entry
//  i_ready_m          in   1             consumer takes o_dataout this cycle
//  i_almostfull_lvl   in   ADDR_WIDTH    free-slot threshold for o_almostfull
//  i_almostempty_lvl  in   ADDR_WIDTH    occupancy threshold for o_almostempty
//  o_full / o_empty   out  1             count==FIFO_DEPTH / count==0
//  o_almostfull       out  1             (FIFO_DEPTH - count) <= i_almostfull_lvl
//  o_almostempty      out  1             count <= i_almostempty_lvl
//  o_count            out  ADDR_WIDTH+1  entries held, 0..FIFO_DEPTH
//  o_max_count        out  ADDR_WIDTH+1  highest o_count since reset/clr_stat
// BEHAVIOUR
//  - push = i_valid_s & o_ready_s; pop = o_valid_m & i_ready_m. o_ready_s = ~o_full & ~i_flush (combinational).
//  - Capacity is exactly FIFO_DEPTH in both modes; with OUT_REG=1 the output register counts as one slot.
//  - Pointers are ADDR_WIDTH+1 bits with an MSB wrap bit; full/empty come from pointer compare, not from o_count.
//  - o_count next = count + push - pop; simultaneous push and pop leaves count unchanged; full-with-push-and-pop is impossible (ready=0).
//  - No bypass: a push into an empty FIFO reaches o_valid_m 1 cycle later (OUT_REG=0) or 1 cycle later via prefetch into out reg (OUT_REG=1).
//  - OUT_REG=1: output register refills from storage in the same cycle it is popped; sustained 1 entry/cycle throughput, no bubbles.
//  - o_dataout is stable while o_valid_m=1 & i_ready_m=0; order strictly FIFO.
//  - Flags o_full/o_empty/o_almost*/o_count are registered or derived from registered state only (no input-to-flag paths except via thresholds).
//  - i_flush: next cycle count=0, pointers=0, o_valid_m=0; push/pop presented in flush cycle discarded; o_max_count unaffected.
//  - o_max_count updates to max(o_max_count, next count) each cycle; i_clr_stat loads current o_count; flush+clr_stat -> 0.
//  - Reset (any time, mid-transfer included): pointers/count/o_max_count=0, o_valid_m=0, o_empty=1, o_full=0,
//    o_almostempty=1, o_almostfull=(FIFO_DEPTH<=lvl), o_ready_s=1 once released; o_dataout=0 if OUT_REG=1,
//    don't-care if OUT_REG=0. Storage array not reset.
//  - Pointer wrap at FIFO_DEPTH is seamless; count arithmetic is ADDR_WIDTH+1 bits, never saturates or wraps.
// TESTING
//  - DEPTH=8, push 0x01..0x08 with i_ready_m=0 -> o_full=1, o_count=8, o_ready_s=0; drain -> 0x01..0x08 in order, o_empty=1.
//  - At full, hold i_valid_s=1 and i_ready_m=1 for 20 cycles -> 1 pop/cycle, refill next cycle, no loss, o_max_count=8.
//  - lvl_af=2, lvl_ae=1: o_almostfull rises at count 6, o_almostempty falls at count 2, both checked every cycle.
//  - Flush at count 5 with concurrent push and pop -> next cycle count=0, o_valid_m=0, o_max_count stays 5; next push reads back correctly.
//  - Assert i_rst_n low mid-stream at count 3 -> all outputs at reset values asynchronously; clean refill after release.
//  - OUT_REG=1: random valid/ready over 10k cycles vs scoreboard -> no loss/dup, o_dataout stable under backpressure.

Source files
------------

// File: rtl/sync_fifo_ctl.sv
// Single-clock valid/ready FIFO with occupancy count, peak watermark, synchronous flush
// and an optional registered output stage that counts as one of the FIFO_DEPTH slots.
module sync_fifo_ctl #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int OUT_REG    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_clr_stat,
    input  logic                  i_valid_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_ready_s,
    output logic                  o_valid_m,
    output logic [DATA_WIDTH-1:0] o_dataout,
    input  logic                  i_ready_m,
    input  logic [ADDR_WIDTH-1:0] i_almostfull_lvl,
    input  logic [ADDR_WIDTH-1:0] i_almostempty_lvl,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almostfull,
    output logic                  o_almostempty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic [ADDR_WIDTH:0]   o_max_count
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d, max_q, max_d;
    logic          push, pop;

    assign o_full        = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                           (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign o_empty       = (wr_ptr_q == rd_ptr_q);
    assign o_ready_s     = ~o_full & ~i_flush;
    assign push          = i_valid_s & o_ready_s;
    assign pop           = o_valid_m & i_ready_m;
    assign o_count       = count_q;
    assign o_max_count   = max_q;
    assign o_almostfull  = (DEPTH_P - count_q) <= {1'b0, i_almostfull_lvl};
    assign o_almostempty = count_q <= {1'b0, i_almostempty_lvl};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        max_d    = max_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + PW'(push) - PW'(pop);
        end
        // clr_stat restarts the watermark from the occupancy seen this cycle
        if (i_flush && i_clr_stat) max_d = '0;
        else if (i_clr_stat)       max_d = count_q;
        else if (count_d > max_q)  max_d = count_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_datain;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // The out reg mirrors mem[rd_ptr]; the entry stays in storage until popped,
            // so pointer compare still sees the true total occupancy.
            logic                  vld_q, vld_d;
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic [ADDR_WIDTH-1:0] nxt_idx;

            assign nxt_idx = rd_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);

            always_comb begin
                vld_d  = vld_q;
                data_d = data_q;
                if (i_flush) begin
                    vld_d = 1'b0;
                end else if (pop || !vld_q) begin
                    vld_d = (count_d != '0);
                    if (pop && count_q > PW'(1)) data_d = mem_q[nxt_idx];
                    else if (push)               data_d = i_datain;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld_q  <= vld_d;
                    data_q <= data_d;
                end
            end

            assign o_valid_m = vld_q;
            assign o_dataout = data_q;
        end else begin : g_out_comb
            assign o_valid_m = ~o_empty;
            assign o_dataout = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Drives one OUT_REG=0 and one OUT_REG=1 instance with identical stimulus and checks
// both against a queue-based reference of the FIFO's observable behaviour.
module tb_sync_fifo_ctl;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AW    = 3;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          flush = 1'b0, clr = 1'b0, vs = 1'b0, rm = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] laf = 3'd2, lae = 3'd1;

    logic          rdy_a, vld_a, full_a, empty_a, af_a, ae_a;
    logic [DW-1:0] dout_a;
    logic [AW:0]   cnt_a, max_a;
    logic          rdy_b, vld_b, full_b, empty_b, af_b, ae_b;
    logic [DW-1:0] dout_b;
    logic [AW:0]   cnt_b, max_b;

    int checks = 0, errors = 0;
    logic [DW-1:0] q[$];
    int maxc = 0;

    always #5 clk = ~clk;

    sync_fifo_ctl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .OUT_REG(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_clr_stat(clr),
        .i_valid_s(vs), .i_datain(din), .o_ready_s(rdy_a), .o_valid_m(vld_a),
        .o_dataout(dout_a), .i_ready_m(rm), .i_almostfull_lvl(laf), .i_almostempty_lvl(lae),
        .o_full(full_a), .o_empty(empty_a), .o_almostfull(af_a), .o_almostempty(ae_a),
        .o_count(cnt_a), .o_max_count(max_a));

    sync_fifo_ctl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .OUT_REG(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_clr_stat(clr),
        .i_valid_s(vs), .i_datain(din), .o_ready_s(rdy_b), .o_valid_m(vld_b),
        .o_dataout(dout_b), .i_ready_m(rm), .i_almostfull_lvl(laf), .i_almostempty_lvl(lae),
        .o_full(full_b), .o_empty(empty_b), .o_almostfull(af_b), .o_almostempty(ae_b),
        .o_count(cnt_b), .o_max_count(max_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_dut(input string s, input logic rdy, input logic vld, input logic [DW-1:0] dout,
                           input logic full, input logic empty, input logic af, input logic ae,
                           input logic [AW:0] cnt, input logic [AW:0] mx);
        int n = q.size();
        chk({s, "_count"}, cnt, n);
        chk({s, "_full"}, full, n == DEPTH);
        chk({s, "_empty"}, empty, n == 0);
        chk({s, "_valid"}, vld, n > 0);
        chk({s, "_ready"}, rdy, (n < DEPTH) && !flush);
        chk({s, "_afull"}, af, (DEPTH - n) <= int'(laf));
        chk({s, "_aempty"}, ae, n <= int'(lae));
        chk({s, "_max"}, mx, maxc);
        if (n > 0) chk({s, "_data"}, dout, q[0]);
    endtask

    task automatic chk_outs();
        chk_dut("a", rdy_a, vld_a, dout_a, full_a, empty_a, af_a, ae_a, cnt_a, max_a);
        chk_dut("b", rdy_b, vld_b, dout_b, full_b, empty_b, af_b, ae_b, cnt_b, max_b);
    endtask

    task automatic chk_reset(input string s);
        chk({s, "_count_a"}, cnt_a, 0);
        chk({s, "_count_b"}, cnt_b, 0);
        chk({s, "_empty_a"}, empty_a, 1);
        chk({s, "_empty_b"}, empty_b, 1);
        chk({s, "_full_a"}, full_a, 0);
        chk({s, "_full_b"}, full_b, 0);
        chk({s, "_valid_a"}, vld_a, 0);
        chk({s, "_valid_b"}, vld_b, 0);
        chk({s, "_aempty_a"}, ae_a, 1);
        chk({s, "_aempty_b"}, ae_b, 1);
        chk({s, "_afull_a"}, af_a, DEPTH <= int'(laf));
        chk({s, "_afull_b"}, af_b, DEPTH <= int'(laf));
        chk({s, "_ready_a"}, rdy_a, 1);
        chk({s, "_ready_b"}, rdy_b, 1);
        chk({s, "_max_a"}, max_a, 0);
        chk({s, "_max_b"}, max_b, 0);
        chk({s, "_dout_b"}, dout_b, 0);
    endtask

    // One clock: drive at negedge, check settled outputs, then advance the model at posedge.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r, input bit f, input bit c);
        int  n;
        bit  pu, po;
        @(negedge clk);
        vs = v; din = d; rm = r; flush = f; clr = c;
        #1;
        chk_outs();
        n  = q.size();
        pu = v && (n < DEPTH) && !f;
        po = r && (n > 0);
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back(d);
        end
        if (f && c)             maxc = 0;
        else if (c)             maxc = n;
        else if (q.size() > maxc) maxc = q.size();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 chk_reset("rst");
        #1 rst_n = 1'b1;

        // fill to full with backpressure, then an extra rejected push
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);

        // streaming at full
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'(32'h100 + i), 1'b1, 1'b0, 1'b0);

        // drain, bounded
        for (int k = 0; k < 40 && q.size() > 0; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("drain_empty", empty_a & empty_b, 1);

        // clear stats, fill to 5, flush with concurrent push/pop, then single round trip
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(32'h200 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hdead, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-stream at count 3
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'h300 + i), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vs = 1'b0; rm = 1'b0; flush = 1'b0; clr = 1'b0;
        #1 chk("pre_rst_count", cnt_b, 3);
        #1 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        q.delete();
        maxc = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1, DW'(32'h400 + i), i[0], 1'b0, 1'b0);

        // randomized traffic with varying ready bias
        for (int i = 0; i < 10000; i++) begin
            int rb = 1 + (i / 1000) % 7;
            if ($urandom_range(199) == 0) begin
                laf = AW'($urandom);
                lae = AW'($urandom);
            end
            cyc(($urandom_range(3) != 0), $urandom, ($urandom_range(7) < rb),
                ($urandom_range(63) == 0), ($urandom_range(96) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
